uart_tx_frame: RTL and testbench

Parametrised UART transmitter for the debug-link UART interface, successor to the fixed 8N1 transmitter. Serialises words of configurable width with optional parity and one or two stop bits, generates the bit clock with a fractional accumulator (no cumulative drift), and inserts ESC/RESUME control frames for link pause. Sits between the debug transport FSM and the pad, with a bypass channel that hands TX_O to a second transmitter.

---
 rtl/uart_tx_frame.sv | 137 +++++++++++++
 tb/tb_uart_tx_frame.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with fractional baud accumulator,
// ESC/RESUME pause frames, ESC byte stuffing and a bypass channel onto TX_O.
module uart_tx_frame #(
    parameter int          CLK_RATE  = 100_000_000,
    parameter int          BAUD_RATE = 115200,
    parameter int          DATA_BITS = 8,
    parameter int          PARITY    = 0,
    parameter int          STOP_BITS = 1,
    parameter logic [7:0]  ESC       = 8'hB1,
    parameter logic [7:0]  RESUME    = 8'h00
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    input  logic                 TX_START_I,
    input  logic [DATA_BITS-1:0] DATA_I,
    output logic                 TX_READY_O,
    output logic                 TX_DONE_O,
    input  logic                 SEND_PAUSE_I,
    input  logic                 CHANNEL_I,
    input  logic                 TX2_I,
    output logic                 TX_O
);
    localparam int AW = $clog2(CLK_RATE + BAUD_RATE);
    localparam logic [AW-1:0]        BAUD_W = AW'(BAUD_RATE);
    localparam logic [AW-1:0]        CLK_W  = AW'(CLK_RATE);
    localparam logic [DATA_BITS-1:0] ESC_W  = DATA_BITS'(ESC);
    localparam logic [DATA_BITS-1:0] RES_W  = DATA_BITS'(RESUME);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q;
    logic                 line_q;
    logic                 pausing_q;
    logic                 stuff_q;
    logic                 data_frame_q;
    logic                 par_q;
    logic                 stop_q;
    logic [AW-1:0]        acc_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;

    logic                 pause_edge;
    logic                 launch;
    logic                 tick;
    logic                 last_stop;
    logic [AW-1:0]        acc_d;
    logic [DATA_BITS-1:0] word_d;
    logic                 parity_d;

    always_comb begin
        pause_edge = SEND_PAUSE_I != pausing_q;
        launch     = state_q == IDLE && !CHANNEL_I && (pause_edge || stuff_q || TX_START_I);
        word_d     = pause_edge ? (SEND_PAUSE_I ? ESC_W : RES_W) : stuff_q ? ESC_W : DATA_I;
        parity_d   = PARITY == 1 ? ~^word_d : ^word_d;
        acc_d      = acc_q + BAUD_W;
        tick       = state_q != IDLE && acc_d >= CLK_W;
        last_stop  = stop_q == 1'(STOP_BITS - 1);
        TX_READY_O = state_q == IDLE && !stuff_q && !pause_edge && !CHANNEL_I;
        TX_DONE_O  = tick && state_q == STOP && last_stop && data_frame_q && !CHANNEL_I;
        TX_O       = CHANNEL_I ? TX2_I : line_q;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q      <= IDLE;
            line_q       <= 1'b1;
            pausing_q    <= 1'b0;
            stuff_q      <= 1'b0;
            data_frame_q <= 1'b0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            acc_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
        end else if (CHANNEL_I) begin
            state_q   <= IDLE;
            line_q    <= 1'b1;
            pausing_q <= 1'b0;
            stuff_q   <= 1'b0;
            acc_q     <= '0;
        end else if (state_q == IDLE) begin
            if (launch) begin
                state_q      <= START;
                line_q       <= 1'b0;
                acc_q        <= '0;
                shift_q      <= word_d;
                par_q        <= parity_d;
                // First half of a stuffed ESC pair is not a completed data word.
                data_frame_q <= !pause_edge && (stuff_q || DATA_I != ESC_W);
                if (pause_edge)
                    pausing_q <= SEND_PAUSE_I;
                else
                    stuff_q <= !stuff_q && DATA_I == ESC_W;
            end
        end else begin
            acc_q <= tick ? acc_d - CLK_W : acc_d;
            if (tick) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        line_q  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                    end
                    DATA: begin
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            stop_q <= 1'b0;
                            if (PARITY != 0) begin
                                state_q <= PAR;
                                line_q  <= par_q;
                            end else begin
                                state_q <= STOP;
                                line_q  <= 1'b1;
                            end
                        end else begin
                            line_q  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 4'd1;
                        end
                    end
                    PAR: begin
                        state_q <= STOP;
                        line_q  <= 1'b1;
                        stop_q  <= 1'b0;
                    end
                    STOP: begin
                        if (last_stop)
                            state_q <= IDLE;
                        else
                            stop_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with scoreboarded frame monitors
// on an 8N1 R=16 instance, a 7E2 R=16 instance and a fractional 100/30 instance.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic       a_rst_n, a_start, a_pause, a_chan, a_tx2;
    logic [7:0] a_data;
    logic       a_ready, a_done, a_tx;
    logic       bc_rst_n, b_start, c_start;
    logic [6:0] b_data;
    logic [7:0] c_data;
    logic       b_ready, b_done, b_tx, c_ready, c_done, c_tx;

    logic [7:0] qa[$];
    logic [7:0] qc[$];
    bit         mon_a = 1'b1;
    int         a_done_cnt = 0, a_done_cyc = 0, b_done_cnt = 0, c_done_cnt = 0;

    uart_tx_frame #(.CLK_RATE(16), .BAUD_RATE(1)) u_a (
        .CLK_I(clk), .RST_NI(a_rst_n), .TX_START_I(a_start), .DATA_I(a_data),
        .TX_READY_O(a_ready), .TX_DONE_O(a_done), .SEND_PAUSE_I(a_pause),
        .CHANNEL_I(a_chan), .TX2_I(a_tx2), .TX_O(a_tx));

    uart_tx_frame #(.CLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .CLK_I(clk), .RST_NI(bc_rst_n), .TX_START_I(b_start), .DATA_I(b_data),
        .TX_READY_O(b_ready), .TX_DONE_O(b_done), .SEND_PAUSE_I(1'b0),
        .CHANNEL_I(1'b0), .TX2_I(1'b1), .TX_O(b_tx));

    uart_tx_frame #(.CLK_RATE(100), .BAUD_RATE(30)) u_c (
        .CLK_I(clk), .RST_NI(bc_rst_n), .TX_START_I(c_start), .DATA_I(c_data),
        .TX_READY_O(c_ready), .TX_DONE_O(c_done), .SEND_PAUSE_I(1'b0),
        .CHANNEL_I(1'b0), .TX2_I(1'b1), .TX_O(c_tx));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return w == 0 ? a_ready : w == 1 ? b_ready : c_ready;
    endfunction

    task automatic wait_rdy(input int w);
        int n = 0;
        while (rdy(w) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", rdy(w), 1);
    endtask

    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            a_done_cnt++;
            a_done_cyc = cyc;
        end
        if (b_done === 1'b1) b_done_cnt++;
        if (c_done === 1'b1) c_done_cnt++;
    end

    logic [7:0] ma_w, ma_e;
    initial forever begin
        @(negedge clk);
        if (mon_a && a_tx === 1'b0) begin
            repeat (8) @(negedge clk);
            chk("a_rx_start", a_tx, 0);
            for (int b = 0; b < 8; b++) begin
                repeat (16) @(negedge clk);
                ma_w[b] = a_tx;
            end
            repeat (16) @(negedge clk);
            chk("a_rx_stop", a_tx, 1);
            chk("a_sb_nonempty", qa.size() != 0, 1);
            ma_e = 8'hxx;
            if (qa.size() != 0) ma_e = qa.pop_front();
            chk("a_rx_data", ma_w, ma_e);
        end
    end

    // Cycle i after the start edge lies in ideal bit floor(i*30/100).
    logic [33:0] mc_s, mc_x;
    logic [7:0]  mc_e;
    logic [9:0]  mc_f;
    initial forever begin
        @(negedge clk);
        if (c_tx === 1'b0) begin
            mc_s[0] = c_tx;
            for (int i = 1; i < 34; i++) begin
                @(negedge clk);
                mc_s[i] = c_tx;
            end
            chk("c_sb_nonempty", qc.size() != 0, 1);
            mc_e = 8'hxx;
            if (qc.size() != 0) mc_e = qc.pop_front();
            mc_f = {1'b1, mc_e, 1'b0};
            for (int i = 0; i < 34; i++) mc_x[i] = mc_f[(30 * i) / 100];
            chk("c_frame_wave", mc_s, mc_x);
        end
    end

    task automatic frame_a(input logic [7:0] d);
        logic [9:0] f;
        int d0;
        f  = {1'b1, d, 1'b0};
        d0 = a_done_cnt;
        @(negedge clk);
        chk("a_ready_pre", a_ready, 1);
        a_data = d;
        a_start = 1'b1;
        qa.push_back(d);
        @(posedge clk);
        #1 a_start = 1'b0;
        for (int j = 0; j < 160; j++) begin
            @(negedge clk);
            chk("a_wave", a_tx, f[j / 16]);
            chk("a_done_time", a_done, j == 159);
            chk("a_ready_busy", a_ready, 0);
        end
        @(negedge clk);
        chk("a_idle_tx", a_tx, 1);
        chk("a_idle_ready", a_ready, 1);
        chk("a_idle_done", a_done, 0);
        chk("a_done_count", a_done_cnt - d0, 1);
    endtask

    task automatic frame_b(input logic [6:0] d);
        logic [10:0] f;
        int d0;
        f  = {2'b11, ^d, d, 1'b0};
        d0 = b_done_cnt;
        @(negedge clk);
        chk("b_ready_pre", b_ready, 1);
        b_data = d;
        b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        for (int j = 0; j < 176; j++) begin
            @(negedge clk);
            chk("b_wave", b_tx, f[j / 16]);
            chk("b_done_time", b_done, j == 175);
        end
        @(negedge clk);
        chk("b_idle_ready", b_ready, 1);
        chk("b_done_count", b_done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, n, cl, prev;
        logic [7:0] w;
        a_rst_n = 1'b0; bc_rst_n = 1'b0;
        a_start = 1'b0; a_pause = 1'b0; a_chan = 1'b0; a_tx2 = 1'b1; a_data = '0;
        b_start = 1'b0; b_data = '0; c_start = 1'b0; c_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_tx", a_tx, 1);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_a_done", a_done, 0);
        chk("rst_b_tx", b_tx, 1);
        chk("rst_c_tx", c_tx, 1);
        chk("rst_c_ready", c_ready, 1);
        a_rst_n = 1'b1; bc_rst_n = 1'b1;
        @(negedge clk);

        frame_a(8'hA5);
        frame_b(7'h13);
        frame_b(7'h55);

        wait_rdy(0);
        @(negedge clk);
        d0 = a_done_cnt;
        a_pause = 1'b1;
        #1 chk("a_ready_pause_pending", a_ready, 0);
        qa.push_back(8'hB1);
        repeat (30) @(negedge clk);
        a_data = 8'h42;
        a_start = 1'b1;
        chk("a_ready_busy_ignore", a_ready, 0);
        @(negedge clk);
        a_start = 1'b0;
        wait_rdy(0);
        a_data = 8'h42;
        a_start = 1'b1;
        qa.push_back(8'h42);
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (30) @(negedge clk);
        a_pause = 1'b0;
        qa.push_back(8'h00);
        n = 0;
        while (a_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("a_done_42_seen", a_done, 1);
        @(negedge clk);
        chk("a_ready_resume_pending", a_ready, 0);
        wait_rdy(0);
        chk("a_pause_done_count", a_done_cnt - d0, 1);

        d0 = a_done_cnt;
        a_data = 8'hB1;
        a_start = 1'b1;
        qa.push_back(8'hB1);
        qa.push_back(8'hB1);
        @(posedge clk);
        #1 a_start = 1'b0;
        cl = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_ready !== 1'b1 && n < 400);
        chk("a_stuff_ready_len", n, 322);
        chk("a_stuff_done_count", a_done_cnt - d0, 1);
        chk("a_stuff_done_cycle", a_done_cyc - cl, 320);

        mon_a = 1'b0;
        d0 = a_done_cnt;
        a_data = 8'h08;
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (72) @(negedge clk);
        chk("a_bit3_before_abort", a_tx, 1);
        a_tx2 = 1'b0;
        a_chan = 1'b1;
        #1 chk("a_chan_tx2_lo", a_tx, 0);
        chk("a_chan_ready", a_ready, 0);
        a_tx2 = 1'b1;
        #1 chk("a_chan_tx2_hi", a_tx, 1);
        a_tx2 = 1'b0;
        repeat (120) @(negedge clk);
        chk("a_chan_follow", a_tx, 0);
        a_chan = 1'b0;
        #1 chk("a_abort_idle_tx", a_tx, 1);
        chk("a_abort_ready", a_ready, 1);
        chk("a_abort_no_done", a_done_cnt - d0, 0);
        a_tx2 = 1'b1;

        a_data = 8'h00;
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (40) @(negedge clk);
        chk("a_bit1_low", a_tx, 0);
        a_rst_n = 1'b0;
        #1 chk("a_rst_tx", a_tx, 1);
        chk("a_rst_ready", a_ready, 1);
        chk("a_rst_done", a_done, 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("a_rst_no_done", a_done_cnt - d0, 0);
        chk("a_rst_idle_tx", a_tx, 1);
        mon_a = 1'b1;
        frame_a(8'h3C);

        prev = 0;
        for (int i = 0; i < 20; i++) begin
            wait_rdy(2);
            w = 8'($urandom_range(0, 255));
            if (w == 8'hB1) w = 8'h4E;
            c_data = w;
            c_start = 1'b1;
            qc.push_back(w);
            @(posedge clk);
            #1 c_start = 1'b0;
            if (i > 0) chk("c_b2b_gap", cyc - prev, 35);
            prev = cyc;
        end
        wait_rdy(2);
        repeat (5) @(negedge clk);
        chk("a_sb_drained", qa.size(), 0);
        chk("c_sb_drained", qc.size(), 0);
        chk("b_done_total", b_done_cnt, 2);
        chk("c_done_total", c_done_cnt, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
